// File: rtl/pe_array_ctrl_if.sv
// pe_array_ctrl_if: configuration, global-buffer read port, PE packet bus and
// status lines of the PE array sequencer, bundled as one interface.
interface pe_array_ctrl_if #(
   parameter int DW = 8,
   parameter int AW = 12
);
   logic            start;
   logic [1:0]      cfg_mode;
   logic [AW-1:0]   cfg_filt_base;
   logic [7:0]      cfg_filt_num;
   logic [AW-1:0]   cfg_if_base;
   logic [15:0]     cfg_if_num;
   logic [4:0]      cfg_if_idx_max;
   logic [15:0]     cfg_psum_num;

   logic            buf_rd_en;
   logic [AW-1:0]   buf_addr;
   logic [4*DW-1:0] buf_rdata;

   logic            array_hold;
   logic            pe_error;
   logic            psum_valid;

   logic            change_mode;
   logic [1:0]      mode_out;
   logic [1:0]      op_stage;
   logic            pkt_valid;
   logic [4:0]      pkt_idx;
   logic [4*DW-1:0] pkt_data;
   logic            busy;
   logic            done;
   logic            error;

   // controller side
   modport master (
      input  start, cfg_mode, cfg_filt_base, cfg_filt_num, cfg_if_base,
             cfg_if_num, cfg_if_idx_max, cfg_psum_num,
             buf_rdata, array_hold, pe_error, psum_valid,
      output buf_rd_en, buf_addr, change_mode, mode_out, op_stage,
             pkt_valid, pkt_idx, pkt_data, busy, done, error
   );

   // host / buffer / array side
   modport slave (
      output start, cfg_mode, cfg_filt_base, cfg_filt_num, cfg_if_base,
             cfg_if_num, cfg_if_idx_max, cfg_psum_num,
             buf_rdata, array_hold, pe_error, psum_valid,
      input  buf_rd_en, buf_addr, change_mode, mode_out, op_stage,
             pkt_valid, pkt_idx, pkt_data, busy, done, error
   );
endinterface

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: PE array sequencer. Latches a layer configuration on start,
// pulses a mode change to all PEs, streams filter then ifmap packets from the
// global buffer onto the shared packet bus, counts psum completions and
// reports a done pulse or a sticky error.
module pe_array_ctrl #(
   parameter int DW      = 8,
   parameter int AW      = 12,
   parameter int NUM_ROW = 6
) (
   input  logic            clk,
   input  logic            rst,
   pe_array_ctrl_if.master io_bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_CFG, S_FLOAD, S_FFLUSH, S_CONV, S_DONE, S_ERR
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [1:0]      r_mode;
   logic [AW-1:0]   r_filt_base;
   logic [7:0]      r_filt_num;
   logic [AW-1:0]   r_if_base;
   logic [15:0]     r_if_num;
   logic [4:0]      r_if_idx_max;
   logic [15:0]     r_psum_num;

   logic [15:0]     r_issued;
   logic [2:0]      r_row;
   logic [1:0]      r_slot;
   logic [4:0]      r_if_idx;
   logic [15:0]     r_psum_cnt;

   logic            r_vld_p1;
   logic [4:0]      r_idx_p1;

   logic            w_in_fload;
   logic            w_in_conv;
   logic            w_rd;
   logic            w_err_go;
   logic            w_row_last;
   logic [15:0]     w_num;
   logic [15:0]     w_psum_next;
   logic [2:0]      w_row_max;
   logic [4:0]      w_issue_idx;
   logic [AW-1:0]   w_addr;
   logic [4*DW-1:0] w_pkt_data;

   // Read issue decision, address/index of the read, psum count including this cycle
   always_comb begin
      w_in_fload  = (r_state == S_FLOAD);
      w_in_conv   = (r_state == S_CONV);
      w_num       = w_in_fload ? {8'd0, r_filt_num} : r_if_num;
      w_rd        = (w_in_fload || w_in_conv) && !io_bus.array_hold && (r_issued < w_num);
      w_addr      = (w_in_fload ? r_filt_base : r_if_base) + r_issued[AW-1:0];
      w_row_max   = (r_mode == 2'd3) ? 3'd2 : 3'(NUM_ROW - 1);
      w_row_last  = (r_row == w_row_max);
      w_issue_idx = w_in_fload ? {r_slot, r_row} : r_if_idx;
      w_err_go    = (r_state != S_IDLE) && io_bus.pe_error;
      w_psum_next = r_psum_cnt + {15'd0, (w_in_conv && io_bus.psum_valid)};
      w_pkt_data  = r_vld_p1 ? io_bus.buf_rdata : '0;
   end

   // Next-state selection and state-decoded outputs
   always_comb begin
      w_state_nxt        = r_state;
      io_bus.buf_rd_en   = w_rd;
      io_bus.buf_addr    = w_rd ? w_addr : '0;
      io_bus.change_mode = 1'b0;
      io_bus.mode_out    = r_mode;
      io_bus.op_stage    = 2'd0;
      io_bus.pkt_valid   = r_vld_p1;
      io_bus.pkt_idx     = r_vld_p1 ? r_idx_p1 : 5'd0;
      io_bus.pkt_data    = w_pkt_data;
      io_bus.busy        = (r_state != S_IDLE);
      io_bus.done        = 1'b0;
      io_bus.error       = 1'b0;
      case (r_state)
         S_IDLE:   if (io_bus.start) w_state_nxt = S_CFG;
         S_CFG: begin
            io_bus.change_mode = 1'b1;
            w_state_nxt        = (r_filt_num != 8'd0) ? S_FLOAD : S_CONV;
         end
         S_FLOAD: begin
            io_bus.op_stage = 2'd1;
            if (w_rd && ((r_issued + 16'd1) == {8'd0, r_filt_num})) w_state_nxt = S_FFLUSH;
         end
         S_FFLUSH: begin
            io_bus.op_stage = 2'd1;
            w_state_nxt     = S_CONV;
         end
         S_CONV: begin
            io_bus.op_stage = 2'd2;
            if ((r_issued >= r_if_num) && (w_psum_next >= r_psum_num)) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            io_bus.done = 1'b1;
            w_state_nxt = S_IDLE;
         end
         S_ERR:    io_bus.error = 1'b1;
         default:  w_state_nxt = S_IDLE;
      endcase
      if (w_err_go) w_state_nxt = S_ERR;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Issue counters, index generators, psum counter, packet-valid pipe
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_mode     <= 2'd0;
         r_issued   <= 16'd0;
         r_row      <= 3'd0;
         r_slot     <= 2'd0;
         r_if_idx   <= 5'd0;
         r_psum_cnt <= 16'd0;
         r_vld_p1   <= 1'b0;
      end else begin
         // a read issued in the cycle the error is seen is never emitted
         r_vld_p1 <= w_rd && !w_err_go;
         if (r_state == S_IDLE && io_bus.start) r_mode <= io_bus.cfg_mode;
         if (r_state == S_CFG) begin
            r_issued <= 16'd0;
            r_row    <= 3'd0;
            r_slot   <= 2'd0;
            r_if_idx <= 5'd0;
         end else if (r_state == S_FFLUSH) begin
            r_issued <= 16'd0;
         end else if (w_rd) begin
            r_issued <= r_issued + 16'd1;
            if (w_in_fload) begin
               if (w_row_last) begin
                  r_row  <= 3'd0;
                  r_slot <= r_slot + 2'd1;
               end else begin
                  r_row  <= r_row + 3'd1;
               end
            end else begin
               r_if_idx <= (r_if_idx == r_if_idx_max) ? 5'd0 : r_if_idx + 5'd1;
            end
         end
         if (r_state == S_CFG)                       r_psum_cnt <= 16'd0;
         else if (w_in_conv && io_bus.psum_valid)    r_psum_cnt <= r_psum_cnt + 16'd1;
      end
   end

   // Layer configuration latch and packet index captured at read issue
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && io_bus.start) begin
         r_filt_base  <= io_bus.cfg_filt_base;
         r_filt_num   <= io_bus.cfg_filt_num;
         r_if_base    <= io_bus.cfg_if_base;
         r_if_num     <= io_bus.cfg_if_num;
         r_if_idx_max <= io_bus.cfg_if_idx_max;
         r_psum_num   <= io_bus.cfg_psum_num;
      end
      r_idx_p1 <= w_issue_idx;
   end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: directed bench for the PE array sequencer with a simple
// global-buffer model and a negedge bus monitor.
module tb_pe_array_ctrl;
   localparam int DW = 8;
   localparam int AW = 12;

   logic clk;
   logic rst;

   pe_array_ctrl_if #(.DW(DW), .AW(AW)) bus();

   pe_array_ctrl #(.DW(DW), .AW(AW), .NUM_ROW(6)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus.master)
   );

   int n_chk = 0;
   int n_err = 0;

   int          cyc = 0;
   int          n_cm = 0;
   int          n_done = 0;
   logic [1:0]  prev_stg = 2'd0;
   logic [4:0]  q_pidx[$];
   logic [31:0] q_pdata[$];
   logic [1:0]  q_pstg[$];
   int          q_pcyc[$];
   logic [11:0] q_addr[$];
   logic [1:0]  q_stg[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_data(input logic [11:0] a);
      return {8'h5A, 4'h0, a, ~a[7:0]};
   endfunction

   // global buffer: data for the address read in the previous cycle
   always @(posedge clk)
      bus.buf_rdata <= bus.buf_rd_en ? exp_data(bus.buf_addr) : 32'hDEAD_BEEF;

   // bus monitor
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (bus.pkt_valid) begin
         q_pidx.push_back(bus.pkt_idx);
         q_pdata.push_back(bus.pkt_data);
         q_pstg.push_back(bus.op_stage);
         q_pcyc.push_back(cyc);
      end
      if (bus.buf_rd_en)   q_addr.push_back(bus.buf_addr);
      if (bus.change_mode) n_cm <= n_cm + 1;
      if (bus.done)        n_done <= n_done + 1;
      if (bus.op_stage != prev_stg) q_stg.push_back(bus.op_stage);
      prev_stg <= bus.op_stage;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ctl_outs();
      return {5'd0, bus.buf_rd_en, bus.buf_addr, bus.change_mode, bus.mode_out,
              bus.op_stage, bus.pkt_valid, bus.pkt_idx, bus.busy, bus.done, bus.error};
   endfunction

   task automatic wait_stage(input logic [1:0] st, input string tag);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (bus.op_stage == st) break;
      end
      chk(tag, bus.op_stage, st);
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (bus.done) break;
      end
      chk(tag, bus.done, 1);
   endtask

   task automatic run_start(input logic [1:0] mode, input logic [11:0] fbase,
                            input logic [7:0] fnum, input logic [11:0] ibase,
                            input logic [15:0] inum, input logic [4:0] imax,
                            input logic [15:0] pnum);
      bus.cfg_mode       = mode;
      bus.cfg_filt_base  = fbase;
      bus.cfg_filt_num   = fnum;
      bus.cfg_if_base    = ibase;
      bus.cfg_if_num     = inum;
      bus.cfg_if_idx_max = imax;
      bus.cfg_psum_num   = pnum;
      bus.start          = 1'b1;
      step();
      bus.start          = 1'b0;
   endtask

   initial begin
      int b;
      int a;
      int cm0;
      int nd0;
      rst = 1'b0;
      bus.start = 1'b0;
      bus.cfg_mode = 2'd0;
      bus.cfg_filt_base = '0;
      bus.cfg_filt_num = '0;
      bus.cfg_if_base = '0;
      bus.cfg_if_num = '0;
      bus.cfg_if_idx_max = '0;
      bus.cfg_psum_num = '0;
      bus.array_hold = 1'b0;
      bus.pe_error = 1'b0;
      bus.psum_valid = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk("reset_outs", ctl_outs(), 0);
      chk("reset_data", bus.pkt_data, 0);
      step();
      rst = 1'b1;
      step();

      // basic MODE1 run
      b = q_pidx.size(); cm0 = n_cm;
      run_start(2'd0, 12'h100, 8'd12, 12'h200, 16'd8, 5'd15, 16'd4);
      wait_stage(2'd2, "t1_reach_conv");
      repeat (12) step();
      @(negedge clk);
      chk("t1_wait_psum_busy", {bus.busy, bus.done}, 2'b10);
      for (int i = 0; i < 4; i++) begin
         step();
         bus.psum_valid = 1'b1;
         @(negedge clk);
         chk("t1_no_early_done", bus.done, 0);
         step();
         bus.psum_valid = 1'b0;
         @(negedge clk);
         chk("t1_done_after_psum", bus.done, (i == 3) ? 1 : 0);
      end
      step();
      chk("t1_idle", {bus.busy, bus.done}, 0);
      chk("t1_change_mode_once", n_cm - cm0, 1);
      chk("t1_pkt_count", q_pidx.size() - b, 20);
      for (int i = 0; i < 12; i++) begin
         chk("t1_fidx", {q_pstg[b+i], q_pidx[b+i]}, {2'd1, 5'(((i / 6) % 4) * 8 + (i % 6))});
         chk("t1_fdata", q_pdata[b+i], exp_data(12'(12'h100 + i)));
      end
      for (int j = 0; j < 8; j++) begin
         chk("t1_iidx", {q_pstg[b+12+j], q_pidx[b+12+j]}, {2'd2, 5'(j)});
         chk("t1_idata", q_pdata[b+12+j], exp_data(12'(12'h200 + j)));
      end
      chk("t1_if_consecutive", q_pcyc[b+19] - q_pcyc[b+12], 7);

      // MODE4 filter indexing with address wrap
      b = q_pidx.size(); a = q_stg.size();
      run_start(2'd3, 12'hFFE, 8'd7, 12'h000, 16'd0, 5'd0, 16'd0);
      @(negedge clk);
      chk("t2_mode_out", bus.mode_out, 3);
      wait_done("t2_done");
      step();
      chk("t2_pkt_count", q_pidx.size() - b, 7);
      for (int i = 0; i < 7; i++) begin
         chk("t2_idx", q_pidx[b+i], ((i / 3) * 8) + (i % 3));
         chk("t2_data", q_pdata[b+i], exp_data(12'(12'hFFE + i)));
      end
      chk("t2_stage_seq", {q_stg[a], q_stg[a+1], q_stg[a+2]}, {2'd1, 2'd2, 2'd0});

      // backpressure mid-ifmap
      b = q_pidx.size(); a = q_addr.size();
      run_start(2'd1, 12'h010, 8'd2, 12'h300, 16'd10, 5'd15, 16'd0);
      wait_stage(2'd2, "t3_reach_conv");
      repeat (3) step();
      bus.array_hold = 1'b1;
      @(negedge clk);
      chk("t3_hold_no_rd0", bus.buf_rd_en, 0);
      chk("t3_inflight_emitted", bus.pkt_valid, 1);
      step();
      @(negedge clk);
      chk("t3_hold_no_rd1", {bus.buf_rd_en, bus.pkt_valid}, 0);
      step();
      @(negedge clk);
      chk("t3_hold_no_rd2", bus.buf_rd_en, 0);
      step();
      bus.array_hold = 1'b0;
      wait_done("t3_done");
      step();
      chk("t3_pkt_count", q_pidx.size() - b, 12);
      chk("t3_rd_count", q_addr.size() - a, 12);
      for (int j = 0; j < 10; j++) begin
         chk("t3_addr", q_addr[a+2+j], 12'(12'h300 + j));
         chk("t3_idx", q_pidx[b+2+j], j);
         chk("t3_data", q_pdata[b+2+j], exp_data(12'(12'h300 + j)));
      end

      // ifmap index wrap
      b = q_pidx.size();
      run_start(2'd0, 12'h000, 8'd0, 12'h040, 16'd6, 5'd3, 16'd0);
      wait_done("t4_done");
      step();
      chk("t4_pkt_count", q_pidx.size() - b, 6);
      chk("t4_idx_seq", {q_pidx[b], q_pidx[b+1], q_pidx[b+2], q_pidx[b+3], q_pidx[b+4], q_pidx[b+5]},
          {5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd1});

      // error path
      run_start(2'd2, 12'h000, 8'd0, 12'h080, 16'd20, 5'd31, 16'd0);
      wait_stage(2'd2, "t5_reach_conv");
      step();
      step();
      bus.pe_error = 1'b1;
      @(negedge clk);
      chk("t5_err_not_yet", bus.error, 0);
      step();
      bus.pe_error = 1'b0;
      b = q_pidx.size(); nd0 = n_done; cm0 = n_cm;
      @(negedge clk);
      chk("t5_error_set", {bus.error, bus.pkt_valid, bus.buf_rd_en}, 3'b100);
      step();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (5) step();
      chk("t5_no_pkt_after_err", q_pidx.size() - b, 0);
      chk("t5_no_done", n_done - nd0, 0);
      chk("t5_start_ignored", n_cm - cm0, 0);
      @(negedge clk);
      chk("t5_sticky", {bus.error, bus.busy, bus.op_stage, bus.buf_rd_en}, 5'b11000);
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("t5_reset_clears", {bus.error, bus.busy}, 0);
      step();
      bus.pe_error = 1'b1;
      step();
      bus.pe_error = 1'b0;
      @(negedge clk);
      chk("t5_idle_pe_error", ctl_outs(), 0);

      // zero counts: done 3 cycles after start
      step();
      bus.cfg_mode = 2'd0; bus.cfg_filt_num = 8'd0; bus.cfg_if_num = 16'd0;
      bus.cfg_psum_num = 16'd0;
      bus.start = 1'b1;
      @(negedge clk);
      chk("t6_s0_idle", bus.busy, 0);
      step();
      bus.start = 1'b0;
      @(negedge clk);
      chk("t6_s1_cfg", {bus.change_mode, bus.done}, 2'b10);
      step();
      @(negedge clk);
      chk("t6_s2_conv", {bus.op_stage, bus.done}, 3'b100);
      step();
      @(negedge clk);
      chk("t6_s3_done", bus.done, 1);
      step();
      @(negedge clk);
      chk("t6_s4_idle", {bus.busy, bus.done}, 0);

      // reset mid-FLOAD, then a fresh run
      step();
      run_start(2'd2, 12'h400, 8'd50, 12'h500, 16'd4, 5'd15, 16'd0);
      wait_stage(2'd1, "t6_reach_fload");
      repeat (2) step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_outs", ctl_outs(), 0);
      chk("t6_rst_data", bus.pkt_data, 0);
      step();
      b = q_pidx.size();
      run_start(2'd2, 12'h400, 8'd3, 12'h500, 16'd2, 5'd15, 16'd0);
      wait_done("t6_fresh_done");
      step();
      chk("t6_fresh_count", q_pidx.size() - b, 5);
      chk("t6_fresh_idx", {q_pidx[b], q_pidx[b+1], q_pidx[b+2], q_pidx[b+3], q_pidx[b+4]},
          {5'd0, 5'd1, 5'd2, 5'd0, 5'd1});
      chk("t6_fresh_data0", q_pdata[b], exp_data(12'h400));
      chk("t6_fresh_data3", q_pdata[b+3], exp_data(12'h500));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
